// File: rtl/xbar_route_sequencer.sv
// Crossbar route sequencer: queues route requests, issues control words, holds each route for its transfer count.
// Optional watchdog in HOLD enabled by XBAR_ROUTE_SEQUENCER_TIMEOUT_EN (adds route_timeout port).
module xbar_route_sequencer #(
  parameter int N_INPUTS          = 2,
  parameter int N_OUTPUTS         = 2,
  parameter int CONTROL_BIT_WIDTH = 42,
  parameter int QUEUE_DEPTH       = 4,
  parameter int COUNT_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic [$clog2(N_INPUTS)+$clog2(N_OUTPUTS)+COUNT_WIDTH-1:0] req_msg,
  input  logic req_val,
  output logic req_rdy,
  output logic [CONTROL_BIT_WIDTH-1:0] control,
  output logic control_val,
  input  logic control_rdy,
  input  logic xfer_fire,
  output logic route_done,
`ifdef XBAR_ROUTE_SEQUENCER_TIMEOUT_EN
  output logic route_timeout,
`endif
  output logic busy
);

  localparam int IW = $clog2(N_INPUTS);
  localparam int OW = $clog2(N_OUTPUTS);
  localparam int SW = IW + OW;
  localparam int MW = SW + COUNT_WIDTH;
  localparam int CW = CONTROL_BIT_WIDTH;
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_e;

  state_e state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [MW-1:0] mem_q [QUEUE_DEPTH];
  logic [MW-1:0] head;
  logic [CW-1:0] ctrl_q, ctrl_d, head_word;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d, head_cnt;
  logic done_q, done_d;
  logic empty, full, push, pop;

`ifdef XBAR_ROUTE_SEQUENCER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [WDW-1:0] WD_ONE = 1;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic to_q, to_d;
  assign route_timeout = to_q;
`endif

  // Extra pointer bit distinguishes full from empty
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign req_rdy = !full;
  assign push = req_val && !full;
  assign head = mem_q[rd_ptr_q[AW-1:0]];
  assign head_cnt = head[COUNT_WIDTH-1:0];

  always_comb begin
    head_word = '0;
    head_word[CW-1 -: SW] = head[MW-1 -: SW];
  end

  always_comb begin
    state_d = state_q;
    ctrl_d = ctrl_q;
    rem_d = rem_q;
    done_d = 1'b0;
    pop = 1'b0;
`ifdef XBAR_ROUTE_SEQUENCER_TIMEOUT_EN
    wdog_d = wdog_q;
    to_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = ISSUE;
      end
      ISSUE: begin
        if (control_rdy) begin
          pop = 1'b1;
          ctrl_d = head_word;
          rem_d = head_cnt;
`ifdef XBAR_ROUTE_SEQUENCER_TIMEOUT_EN
          wdog_d = '0;
`endif
          if (head_cnt != '0) begin
            state_d = HOLD;
          end else begin
            state_d = IDLE;
            done_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (xfer_fire) begin
          rem_d = rem_q - CNT_ONE;
`ifdef XBAR_ROUTE_SEQUENCER_TIMEOUT_EN
          wdog_d = '0;
`endif
          if (rem_q == CNT_ONE) begin
            state_d = IDLE;
            done_d = 1'b1;
          end
        end
`ifdef XBAR_ROUTE_SEQUENCER_TIMEOUT_EN
        else if (wdog_q == WD_LAST) begin
          state_d = IDLE;
          to_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_ONE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ctrl_q <= '0;
      rem_q <= '0;
      done_q <= 1'b0;
`ifdef XBAR_ROUTE_SEQUENCER_TIMEOUT_EN
      wdog_q <= '0;
      to_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ctrl_q <= ctrl_d;
      rem_q <= rem_d;
      done_q <= done_d;
`ifdef XBAR_ROUTE_SEQUENCER_TIMEOUT_EN
      wdog_q <= wdog_d;
      to_q <= to_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= req_msg;
  end

  assign control = (state_q == ISSUE) ? head_word : ctrl_q;
  assign control_val = (state_q == ISSUE);
  assign route_done = done_q;
  assign busy = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_xbar_route_sequencer.sv
// Directed bench for xbar_route_sequencer: hand-computed vectors, one check task.
// Define XBAR_ROUTE_SEQUENCER_TIMEOUT_EN to exercise the watchdog instead of the indefinite hold.
module tb_xbar_route_sequencer;

`ifdef XBAR_ROUTE_SEQUENCER_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic clk;
  logic reset;
  logic [9:0] req_msg;
  logic req_val;
  logic req_rdy;
  logic [41:0] control;
  logic control_val;
  logic control_rdy;
  logic xfer_fire;
  logic route_done;
  logic busy;
`ifdef XBAR_ROUTE_SEQUENCER_TIMEOUT_EN
  logic route_timeout;
`endif

  int n_vec = 0;
  int n_bad = 0;

  xbar_route_sequencer #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_msg(req_msg),
    .req_val(req_val),
    .req_rdy(req_rdy),
    .control(control),
    .control_val(control_val),
    .control_rdy(control_rdy),
    .xfer_fire(xfer_fire),
    .route_done(route_done),
`ifdef XBAR_ROUTE_SEQUENCER_TIMEOUT_EN
    .route_timeout(route_timeout),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [41:0] enc(input logic i, input logic o);
    return {i, o, 40'b0};
  endfunction

  logic [41:0] exp_ctl [4];
  int n_iss;
  int n_done;
  logic seen;

  initial begin
    reset = 1'b1;
    req_msg = '0;
    req_val = 1'b0;
    control_rdy = 1'b0;
    xfer_fire = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_rdy", req_rdy, 1);
    chk("rst_ctl", control, 0);
    chk("rst_val", control_val, 0);
    chk("rst_done", route_done, 0);
    chk("rst_busy", busy, 0);

    // route in=1 out=0 count=3
    req_msg = {1'b1, 1'b0, 8'd3};
    req_val = 1'b1;
    control_rdy = 1'b1;
    step();
    req_val = 1'b0;
    chk("t1_val_t1", control_val, 0);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_val_t2", control_val, 1);
    chk("t1_ctl_t2", control, enc(1'b1, 1'b0));
    step();
    chk("t1_val_hold", control_val, 0);
    chk("t1_ctl_hold", control, enc(1'b1, 1'b0));
    xfer_fire = 1'b1;
    step();
    chk("t1_done_f1", route_done, 0);
    step();
    chk("t1_done_f2", route_done, 0);
    chk("t1_val_f2", control_val, 0);
    step();
    xfer_fire = 1'b0;
    chk("t1_done", route_done, 1);
    chk("t1_busy_end", busy, 0);
    step();
    chk("t1_done_off", route_done, 0);

    // route in=0 out=1 count=0
    req_msg = {1'b0, 1'b1, 8'd0};
    req_val = 1'b1;
    step();
    req_val = 1'b0;
    step();
    chk("t2_val", control_val, 1);
    chk("t2_ctl", control, enc(1'b0, 1'b1));
    step();
    chk("t2_done", route_done, 1);
    chk("t2_nohold", busy, 0);
    chk("t2_val_off", control_val, 0);
    step();

    // fill queue with control_rdy low
    exp_ctl[0] = enc(1'b0, 1'b1);
    exp_ctl[1] = enc(1'b1, 1'b0);
    exp_ctl[2] = enc(1'b0, 1'b0);
    exp_ctl[3] = enc(1'b1, 1'b1);
    control_rdy = 1'b0;
    req_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: req_msg = {1'b1, 1'b1, 8'd0};
        1: req_msg = {1'b0, 1'b1, 8'd0};
        2: req_msg = {1'b1, 1'b0, 8'd0};
        default: req_msg = {1'b0, 1'b0, 8'd0};
      endcase
      chk("t3_rdy", req_rdy, 1);
      step();
    end
    req_msg = {1'b1, 1'b1, 8'd0};
    for (int k = 0; k < 6; k++) begin
      chk("t3_full", req_rdy, 0);
      chk("t4_val", control_val, 1);
      chk("t4_ctl", control, enc(1'b1, 1'b1));
      step();
    end
    chk("t3_still_full", req_rdy, 0);
    control_rdy = 1'b1;
    step();
    chk("t3_done_e1", route_done, 1);
    chk("t3_rdy_pop", req_rdy, 1);
    step();
    req_val = 1'b0;
    chk("t3_refull", req_rdy, 0);
    n_iss = 0;
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      if (control_val && control_rdy) begin
        if (n_iss < 4) chk("t3_order", control, exp_ctl[n_iss]);
        n_iss++;
      end
      if (route_done) n_done++;
      step();
    end
    chk("t3_issued", n_iss, 4);
    chk("t3_dones", n_done, 4);
    chk("t3_idle", busy, 0);

    // reset in HOLD with remaining = 2 and a queued request
    req_msg = {1'b1, 1'b1, 8'd5};
    req_val = 1'b1;
    step();
    req_val = 1'b0;
    step();
    step();
    req_msg = {1'b0, 1'b0, 8'd1};
    req_val = 1'b1;
    xfer_fire = 1'b1;
    step();
    req_val = 1'b0;
    step();
    step();
    xfer_fire = 1'b0;
    chk("t5_hold_busy", busy, 1);
    chk("t5_hold_val", control_val, 0);
    reset = 1'b1;
    step();
    chk("t5_ctl", control, 0);
    chk("t5_val", control_val, 0);
    chk("t5_done", route_done, 0);
    chk("t5_busy", busy, 0);
    chk("t5_rdy", req_rdy, 1);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (route_done || control_val || busy) seen = 1'b1;
    end
    chk("t5_quiet", seen, 0);

    // HOLD with no transfers
    req_msg = {1'b0, 1'b1, 8'd1};
    req_val = 1'b1;
    step();
    req_val = 1'b0;
    step();
    step();
    chk("t6_in_hold", control_val, 0);
`ifdef XBAR_ROUTE_SEQUENCER_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      chk("t6_to_early", route_timeout, 0);
      step();
    end
    chk("t6_timeout", route_timeout, 1);
    chk("t6_to_nodone", route_done, 0);
    chk("t6_to_idle", busy, 0);
    step();
    chk("t6_to_off", route_timeout, 0);
`else
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (route_done) seen = 1'b1;
      step();
    end
    chk("t6_no_done", seen, 0);
    chk("t6_waiting", busy, 1);
    xfer_fire = 1'b1;
    step();
    xfer_fire = 1'b0;
    chk("t6_done", route_done, 1);
    chk("t6_idle", busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
